// File: rtl/ps2_kbd_cmd_ctrl_pkg.sv
// ps2_cmd_pkg: shared constants and encodings for the PS/2 keyboard
// command sequencer (command/response bytes, FSM states, LED phases).
package ps2_cmd_pkg;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_LED  = 8'hED;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_TX,
    ST_WAIT_ACK,
    ST_WAIT_BAT
  } state_e;

  // PH_NONE marks a reset exchange so its ACK is never
  // mistaken for the LED command ACK.
  typedef enum logic [1:0] {
    PH_NONE,
    PH_CMD,
    PH_ARG
  } phase_e;

endpackage

// File: rtl/ps2_kbd_cmd_ctrl_if.sv
// ps2_kbd_cmd_ctrl_if: link between the command sequencer and the PS/2
// byte transmitter / receiver (tx strobe+status, rx byte stream).
interface ps2_kbd_cmd_ctrl_if;

  logic [7:0] tx_data;
  logic       tx_req;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic [7:0] rx_data;
  logic       rx_valid;

  // master: the sequencer
  modport master (
    output tx_data,
    output tx_req,
    input  tx_busy,
    input  tx_done,
    input  tx_error,
    input  rx_data,
    input  rx_valid
  );

  // slave: the PS/2 transmitter / receiver side
  modport slave (
    input  tx_data,
    input  tx_req,
    output tx_busy,
    output tx_done,
    output tx_error,
    output rx_data,
    output rx_valid
  );

endinterface

// File: rtl/ps2_kbd_cmd_ctrl_timer.sv
// ps2_cmd_timer: loadable down-counter, saturating at zero.
// Ports: clk_i, rst_ni, load_i/val_i (load), en_i (count), expired_o.
module ps2_cmd_timer #(
  parameter int W = 25
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/ps2_kbd_cmd_ctrl.sv
// ps2_kbd_cmd_ctrl: host-side PS/2 keyboard command sequencer.
// Ports: clk_i/rst_ni; link (tx/rx master); rst_req_i, led_req_i, led_i
// requests; kbd_data_o/kbd_valid_o forwarded bytes; busy/done/err/bat_ok.
module ps2_kbd_cmd_ctrl
  import ps2_cmd_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 500000,
  parameter int unsigned BAT_TIMEOUT = 25000000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  ps2_kbd_cmd_ctrl_if.master link,
  input  logic       rst_req_i,
  input  logic       led_req_i,
  input  logic [2:0] led_i,
  output logic [7:0] kbd_data_o,
  output logic       kbd_valid_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic       bat_ok_o
);

  localparam int unsigned TMAX =
    (ACK_TIMEOUT > BAT_TIMEOUT) ? ACK_TIMEOUT : BAT_TIMEOUT;
  localparam int TW = $clog2(TMAX + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0] T_ACK = TW'(ACK_TIMEOUT);
  localparam logic [TW-1:0] T_BAT = TW'(BAT_TIMEOUT);
  localparam logic [RW-1:0] R_MAX = RW'(MAX_RETRY);

  state_e        state_q, state_d;
  phase_e        phase_q, phase_d;
  logic [7:0]    byte_q, byte_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [2:0]    ledv_q, ledv_d;
  logic          rpend_q, rpend_d;
  logic          lpend_q, lpend_d;
  logic          bat_q, bat_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [7:0]    kdata_q;
  logic          kvalid_q;

  logic          rst_clr, led_clr;
  logic          consume, do_retry;
  logic          t_load, t_en, t_exp;
  logic [TW-1:0] t_val;
  logic          fwd;

  ps2_cmd_timer #(
    .W (TW)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (t_load),
    .val_i     (t_val),
    .en_i      (t_en),
    .expired_o (t_exp)
  );

  assign t_en = (state_q == ST_WAIT_ACK)
             || (state_q == ST_WAIT_BAT);

  // A request in the same cycle its flag clears keeps the flag set.
  assign rpend_d = (rpend_q && !rst_clr) || rst_req_i;
  assign lpend_d = (lpend_q && !led_clr) || led_req_i;
  assign ledv_d  = led_req_i ? led_i : ledv_q;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    byte_d   = byte_q;
    retry_d  = retry_q;
    bat_d    = bat_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rst_clr  = 1'b0;
    led_clr  = 1'b0;
    consume  = 1'b0;
    do_retry = 1'b0;
    t_load   = 1'b0;
    t_val    = '0;

    case (state_q)
      ST_IDLE: begin
        if (rpend_q) begin
          byte_d  = CMD_RESET;
          phase_d = PH_NONE;
          rst_clr = 1'b1;
          bat_d   = 1'b0;
          retry_d = '0;
          state_d = ST_SEND;
        end else if (lpend_q) begin
          byte_d  = CMD_SET_LED;
          phase_d = PH_CMD;
          led_clr = 1'b1;
          retry_d = '0;
          state_d = ST_SEND;
        end
      end

      ST_SEND: begin
        if (!link.tx_busy) state_d = ST_WAIT_TX;
      end

      ST_WAIT_TX: begin
        if (link.tx_done) begin
          state_d = ST_WAIT_ACK;
          t_load  = 1'b1;
          t_val   = T_ACK;
        end else if (link.tx_error) begin
          do_retry = 1'b1;
        end
      end

      ST_WAIT_ACK: begin
        // An rx byte takes precedence over a same-cycle expiry.
        if (link.rx_valid) begin
          unique case (1'b1)
            (link.rx_data == RSP_ACK): begin
              consume = 1'b1;
              if (phase_q == PH_CMD) begin
                byte_d  = {5'b0, ledv_d};
                phase_d = PH_ARG;
                retry_d = '0;
                state_d = ST_SEND;
              end else if (byte_q == CMD_RESET) begin
                t_load  = 1'b1;
                t_val   = T_BAT;
                state_d = ST_WAIT_BAT;
              end else begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end
            end
            (link.rx_data == RSP_RESEND): begin
              consume  = 1'b1;
              do_retry = 1'b1;
            end
            default: ;
          endcase
        end else if (t_exp) begin
          do_retry = 1'b1;
        end
      end

      ST_WAIT_BAT: begin
        if (link.rx_valid) begin
          unique case (1'b1)
            (link.rx_data == RSP_BAT_OK): begin
              consume = 1'b1;
              bat_d   = 1'b1;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
            (link.rx_data == RSP_BAT_FAIL): begin
              consume = 1'b1;
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
            default: ;
          endcase
        end else if (t_exp) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (do_retry) begin
      if (retry_q < R_MAX) begin
        retry_d = retry_q + RW'(1);
        state_d = ST_SEND;
      end else begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

  assign fwd = link.rx_valid && !consume;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      phase_q  <= PH_NONE;
      byte_q   <= '0;
      retry_q  <= '0;
      ledv_q   <= '0;
      rpend_q  <= 1'b0;
      lpend_q  <= 1'b0;
      bat_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      kdata_q  <= '0;
      kvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      byte_q   <= byte_d;
      retry_q  <= retry_d;
      ledv_q   <= ledv_d;
      rpend_q  <= rpend_d;
      lpend_q  <= lpend_d;
      bat_q    <= bat_d;
      done_q   <= done_d;
      err_q    <= err_d;
      kvalid_q <= fwd;
      if (fwd) kdata_q <= link.rx_data;
    end
  end

  assign link.tx_req  = (state_q == ST_SEND) && !link.tx_busy;
  assign link.tx_data = byte_q;

  assign kbd_data_o  = kdata_q;
  assign kbd_valid_o = kvalid_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign bat_ok_o    = bat_q;

endmodule

// File: tb/tb_ps2_kbd_cmd_ctrl.sv
// tb_ps2_kbd_cmd_ctrl: directed bench for the PS/2 command sequencer.
// Inputs change 2 time units after posedge; outputs counted at negedge.
module tb_ps2_kbd_cmd_ctrl;

  logic       clk;
  logic       rst_n;
  logic       rst_req;
  logic       led_req;
  logic [2:0] led;
  logic [7:0] kbd_data;
  logic       kbd_valid;
  logic       busy;
  logic       done;
  logic       err;
  logic       bat_ok;

  ps2_kbd_cmd_ctrl_if bus ();

  ps2_kbd_cmd_ctrl #(
    .ACK_TIMEOUT (100),
    .BAT_TIMEOUT (200),
    .MAX_RETRY   (3)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .link        (bus),
    .rst_req_i   (rst_req),
    .led_req_i   (led_req),
    .led_i       (led),
    .kbd_data_o  (kbd_data),
    .kbd_valid_o (kbd_valid),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .bat_ok_o    (bat_ok)
  );

  int total = 0;
  int bad   = 0;
  int n_done = 0;
  int n_err  = 0;
  int n_tx   = 0;
  logic [7:0] kq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) n_done++;
    if (err) n_err++;
    if (bus.tx_req) n_tx++;
    if (kbd_valid) kq.push_back(kbd_data);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_rx(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_done();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  task automatic req_led(input logic [2:0] v);
    led     = v;
    led_req = 1'b1;
    tick();
    led_req = 1'b0;
  endtask

  // Waits (bounded) for a tx strobe, then steps past SEND.
  task automatic wait_tx(output logic ok, output logic [7:0] b);
    ok = 1'b0;
    b  = 8'h00;
    for (int i = 0; i < 50; i++) begin
      if (bus.tx_req) begin
        ok = 1'b1;
        b  = bus.tx_data;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy got=%b want=0", busy);
    end
    total++;
    if ({done, err, bat_ok, kbd_valid} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0000",
               {done, err, bat_ok, kbd_valid});
    end
    total++;
    if (bus.tx_req !== 1'b0 || kbd_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_data got=%b/%h want=0/00",
               bus.tx_req, kbd_data);
    end
  endtask

  task automatic test_led();
    logic ok;
    logic [7:0] b;
    int d0, t0, k0;
    d0 = n_done;
    t0 = n_tx;
    k0 = kq.size();
    req_led(3'b100);
    wait_tx(ok, b);
    total++;
    if (!ok || b !== 8'hED) begin
      bad++;
      $display("FAIL led_cmd got=%h ok=%b want=ed", b, ok);
    end
    pulse_done();
    send_rx(8'hFA);
    wait_tx(ok, b);
    total++;
    if (!ok || b !== 8'h04) begin
      bad++;
      $display("FAIL led_arg got=%h ok=%b want=04", b, ok);
    end
    pulse_done();
    send_rx(8'hFA);
    tick();
    total++;
    if (n_done - d0 != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL led_done got=%0d/%b want=1/0",
               n_done - d0, busy);
    end
    total++;
    if (kq.size() != k0 || n_tx - t0 != 2) begin
      bad++;
      $display("FAIL led_fwd got=%0d/%0d want=0/2",
               kq.size() - k0, n_tx - t0);
    end
  endtask

  task automatic test_rst_and_led();
    logic ok;
    logic [7:0] b;
    int d0;
    d0 = n_done;
    led     = 3'b010;
    rst_req = 1'b1;
    led_req = 1'b1;
    tick();
    rst_req = 1'b0;
    led_req = 1'b0;
    wait_tx(ok, b);
    total++;
    if (!ok || b !== 8'hFF) begin
      bad++;
      $display("FAIL both_first got=%h ok=%b want=ff", b, ok);
    end
    pulse_done();
    send_rx(8'hFA);
    tick();
    total++;
    if (busy !== 1'b1 || bat_ok !== 1'b0) begin
      bad++;
      $display("FAIL bat_wait got=%b/%b want=1/0", busy, bat_ok);
    end
    send_rx(8'hAA);
    total++;
    if (bat_ok !== 1'b1 || done !== 1'b1) begin
      bad++;
      $display("FAIL bat_ok got=%b/%b want=1/1", bat_ok, done);
    end
    wait_tx(ok, b);
    total++;
    if (!ok || b !== 8'hED) begin
      bad++;
      $display("FAIL both_led got=%h ok=%b want=ed", b, ok);
    end
    pulse_done();
    send_rx(8'hFA);
    wait_tx(ok, b);
    total++;
    if (!ok || b !== 8'h02) begin
      bad++;
      $display("FAIL both_arg got=%h ok=%b want=02", b, ok);
    end
    pulse_done();
    send_rx(8'hFA);
    tick();
    total++;
    if (n_done - d0 != 2 || bat_ok !== 1'b1) begin
      bad++;
      $display("FAIL both_done got=%0d/%b want=2/1",
               n_done - d0, bat_ok);
    end
  endtask

  task automatic test_resend();
    logic ok;
    logic [7:0] b;
    int e0, t0;
    e0 = n_err;
    t0 = n_tx;
    req_led(3'b001);
    wait_tx(ok, b);
    pulse_done();
    for (int i = 0; i < 3; i++) begin
      send_rx(8'hFE);
      wait_tx(ok, b);
      total++;
      if (!ok || b !== 8'hED) begin
        bad++;
        $display("FAIL resend_%0d got=%h ok=%b want=ed", i, b, ok);
      end
      pulse_done();
    end
    send_rx(8'hFE);
    tick();
    total++;
    if (n_err - e0 != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL resend_err got=%0d/%b want=1/0",
               n_err - e0, busy);
    end
    total++;
    if (n_tx - t0 != 4) begin
      bad++;
      $display("FAIL resend_cnt got=%0d want=4", n_tx - t0);
    end
  endtask

  // Timer holds 100 after the tx_done edge and reaches 0 at edge 100;
  // the expiry is acted on at edge 101, where SEND (or err_o) appears.
  task automatic test_timeout();
    logic ok;
    logic [7:0] b;
    int n, e0;
    e0 = n_err;
    req_led(3'b011);
    wait_tx(ok, b);
    pulse_done();
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!bus.tx_req && n < 200) begin
        tick();
        n++;
      end
      total++;
      if (n != 101 || bus.tx_data !== 8'hED) begin
        bad++;
        $display("FAIL tmo_resend_%0d got=%0d/%h want=101/ed",
                 i, n, bus.tx_data);
      end
      tick();
      pulse_done();
    end
    n = 0;
    while (!err && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (n != 101 || n_err - e0 != 0) begin
      bad++;
      $display("FAIL tmo_err got=%0d/%0d want=101/0",
               n, n_err - e0);
    end
    tick();
    total++;
    if (n_err - e0 != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL tmo_idle got=%0d/%b want=1/0",
               n_err - e0, busy);
    end
  endtask

  task automatic test_fwd_wait_ack();
    logic ok;
    logic [7:0] b;
    int k0;
    req_led(3'b110);
    wait_tx(ok, b);
    pulse_done();
    k0 = kq.size();
    send_rx(8'h1C);
    total++;
    if (kbd_valid !== 1'b1 || kbd_data !== 8'h1C) begin
      bad++;
      $display("FAIL ack_fwd got=%b/%h want=1/1c",
               kbd_valid, kbd_data);
    end
    send_rx(8'hFA);
    total++;
    if (kbd_valid !== 1'b0) begin
      bad++;
      $display("FAIL ack_consumed got=%b want=0", kbd_valid);
    end
    wait_tx(ok, b);
    total++;
    if (!ok || b !== 8'h06) begin
      bad++;
      $display("FAIL ack_arg got=%h ok=%b want=06", b, ok);
    end
    pulse_done();
    send_rx(8'hFA);
    tick();
    total++;
    if (kq.size() - k0 != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ack_total got=%0d/%b want=1/0",
               kq.size() - k0, busy);
    end
  endtask

  task automatic test_back_to_back();
    bus.rx_data  = 8'hF0;
    bus.rx_valid = 1'b1;
    tick();
    total++;
    if (kbd_valid !== 1'b1 || kbd_data !== 8'hF0) begin
      bad++;
      $display("FAIL b2b_0 got=%b/%h want=1/f0",
               kbd_valid, kbd_data);
    end
    bus.rx_data = 8'h1C;
    tick();
    bus.rx_valid = 1'b0;
    total++;
    if (kbd_valid !== 1'b1 || kbd_data !== 8'h1C) begin
      bad++;
      $display("FAIL b2b_1 got=%b/%h want=1/1c",
               kbd_valid, kbd_data);
    end
    tick();
    total++;
    if (kbd_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end got=%b want=0", kbd_valid);
    end
    send_rx(8'hFA);
    total++;
    if (kbd_valid !== 1'b1 || kbd_data !== 8'hFA || busy) begin
      bad++;
      $display("FAIL idle_fa got=%b/%h/%b want=1/fa/0",
               kbd_valid, kbd_data, busy);
    end
    send_rx(8'hAA);
    total++;
    if (kbd_valid !== 1'b1 || kbd_data !== 8'hAA) begin
      bad++;
      $display("FAIL idle_aa got=%b/%h want=1/aa",
               kbd_valid, kbd_data);
    end
  endtask

  task automatic test_reset_mid_bat();
    logic ok;
    logic [7:0] b;
    int e0;
    e0 = n_err;
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    wait_tx(ok, b);
    pulse_done();
    send_rx(8'hFA);
    send_rx(8'h55);
    total++;
    if (busy !== 1'b1 || kbd_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_bat got=%b/%b want=1/1", busy, kbd_valid);
    end
    rst_n = 1'b0;
    tick();
    total++;
    if ({busy, done, err, bat_ok, kbd_valid, bus.tx_req}
        !== 6'b0 || kbd_data !== 8'h00) begin
      bad++;
      $display("FAIL mid_rst got=%b/%h want=000000/00",
               {busy, done, err, bat_ok, kbd_valid, bus.tx_req},
               kbd_data);
    end
    rst_n = 1'b1;
    repeat (5) tick();
    total++;
    if (n_err != e0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_noerr got=%0d/%b want=0/0",
               n_err - e0, busy);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    rst_req      = 1'b0;
    led_req      = 1'b0;
    led          = 3'b000;
    bus.tx_busy  = 1'b0;
    bus.tx_done  = 1'b0;
    bus.tx_error = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    test_reset();
    test_led();
    test_rst_and_led();
    test_resend();
    test_timeout();
    test_fwd_wait_ack();
    test_back_to_back();
    test_reset_mid_bat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
